// File: rtl/fadd_pipe.sv
// fadd_pipe: three-stage pipelined floating-point adder/subtractor for an
// arbitrary {sign, EXP_W exponent, MAN_W fraction} format. Rounds to nearest
// even and raises {invalid, overflow, underflow, inexact}. An opaque tag
// travels with each operation. The order/accepted handshake feeds the pipe.
// The done/taken handshake drains it, and backpressure ripples back stage by
// stage.
module fadd_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     order,
  input  logic                     op,
  input  logic [TAG_W-1:0]         tag,
  input  logic [EXP_W+MAN_W:0]     rs1,
  input  logic [EXP_W+MAN_W:0]     rs2,
  output logic                     accepted,
  output logic                     done,
  input  logic                     taken,
  output logic [EXP_W+MAN_W:0]     rd,
  output logic [TAG_W-1:0]         tag_out,
  output logic [3:0]               flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  // Significand plus guard, round and sticky: hidden bit sits at SW-1.
  localparam int SW  = MAN_W + 4;
  localparam int SAT = MAN_W + 3;
  localparam int SHW = $clog2(SW);
  localparam int LZW = $clog2(SW + 1);

  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Handshake: a stage may load when it is empty or the stage ahead moves on.
  // ---------------------------------------------------------------------------
  logic r1_v, r2_v, r3_v;
  logic w_adv1, w_adv2, w_adv3;

  assign w_adv3   = ~r3_v | taken;
  assign w_adv2   = ~r2_v | w_adv3;
  assign w_adv1   = ~r1_v | w_adv2;
  assign accepted = order & w_adv1 & ~rstn;
  assign done     = r3_v;

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: unpack, classify, swap by magnitude, align.
  // ---------------------------------------------------------------------------
  logic             w_sa, w_sb;
  logic [EXP_W-1:0] w_ea, w_eb;
  logic [MAN_W-1:0] w_fa, w_fb;
  logic             w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf;
  logic [EXP_W-1:0] w_ea_eff, w_eb_eff, w_big_e, w_small_e, w_d;
  logic [MAN_W:0]   w_sig_a, w_sig_b, w_big_sig, w_small_sig;
  logic             w_a_big, w_big_sign;
  logic [SHW-1:0]   w_shamt;
  logic [SW-1:0]    w_small_ext, w_small_sh, w_small_al, w_lost;
  logic             w_spec, w_spec_inv;
  logic [W-1:0]     w_spec_val;

  assign w_sa = rs1[W-1];
  assign w_ea = rs1[W-2 -: EXP_W];
  assign w_fa = rs1[MAN_W-1:0];
  // Subtraction is addition with the second operand's sign flipped.
  assign w_sb = rs2[W-1] ^ op;
  assign w_eb = rs2[W-2 -: EXP_W];
  assign w_fb = rs2[MAN_W-1:0];

  assign w_a_nan  = (&w_ea) & (|w_fa);
  assign w_b_nan  = (&w_eb) & (|w_fb);
  assign w_a_snan = w_a_nan & ~w_fa[MAN_W-1];
  assign w_b_snan = w_b_nan & ~w_fb[MAN_W-1];
  assign w_a_inf  = (&w_ea) & ~(|w_fa);
  assign w_b_inf  = (&w_eb) & ~(|w_fb);

  // Pick the larger magnitude as the base so subtraction never goes negative.
  always_comb begin
    w_ea_eff = (w_ea == '0) ? EXP_W'(1) : w_ea;
    w_eb_eff = (w_eb == '0) ? EXP_W'(1) : w_eb;
    w_sig_a  = {|w_ea, w_fa};
    w_sig_b  = {|w_eb, w_fb};
    w_a_big  = {w_ea_eff, w_sig_a} >= {w_eb_eff, w_sig_b};
    if (w_a_big) begin
      w_big_e     = w_ea_eff;
      w_small_e   = w_eb_eff;
      w_big_sig   = w_sig_a;
      w_small_sig = w_sig_b;
      w_big_sign  = w_sa;
    end else begin
      w_big_e     = w_eb_eff;
      w_small_e   = w_ea_eff;
      w_big_sig   = w_sig_b;
      w_small_sig = w_sig_a;
      w_big_sign  = w_sb;
    end
    w_d     = w_big_e - w_small_e;
    w_shamt = (32'(w_d) > 32'(SAT)) ? SHW'(SAT) : SHW'(w_d);
  end

  assign w_small_ext = {w_small_sig, 3'b000};
  assign w_small_sh  = w_small_ext >> w_shamt;

  // Every bit shifted out of the small operand folds into the sticky bit.
  generate
    for (genvar gi = 0; gi < SW; gi++) begin : g_lost
      assign w_lost[gi] = w_small_ext[gi] & (SHW'(gi) < w_shamt);
    end
  endgenerate

  assign w_small_al = {w_small_sh[SW-1:1], w_small_sh[0] | (|w_lost)};

  // NaN and infinity operands bypass the datapath with a precomputed result.
  always_comb begin
    w_spec     = 1'b0;
    w_spec_inv = 1'b0;
    w_spec_val = '0;
    if (w_a_nan | w_b_nan) begin
      w_spec     = 1'b1;
      w_spec_val = QNAN;
      w_spec_inv = w_a_snan | w_b_snan;
    end else if (w_a_inf & w_b_inf & (w_sa ^ w_sb)) begin
      w_spec     = 1'b1;
      w_spec_val = QNAN;
      w_spec_inv = 1'b1;
    end else if (w_a_inf) begin
      w_spec     = 1'b1;
      w_spec_val = {w_sa, EXP_ONES, {MAN_W{1'b0}}};
    end else if (w_b_inf) begin
      w_spec     = 1'b1;
      w_spec_val = {w_sb, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  logic             r1_sign, r1_sub, r1_spec, r1_spec_inv;
  logic [EXP_W-1:0] r1_exp;
  logic [SW-1:0]    r1_big, r1_small;
  logic [W-1:0]     r1_spec_val;
  logic [TAG_W-1:0] r1_tag;

  // Stage 1 register: capture aligned operands when an order is accepted.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r1_v        <= 1'b0;
      r1_sign     <= 1'b0;
      r1_sub      <= 1'b0;
      r1_exp      <= '0;
      r1_big      <= '0;
      r1_small    <= '0;
      r1_spec     <= 1'b0;
      r1_spec_inv <= 1'b0;
      r1_spec_val <= '0;
      r1_tag      <= '0;
    end else if (w_adv1) begin
      r1_v <= order;
      if (order) begin
        r1_sign     <= w_big_sign;
        r1_sub      <= w_sa ^ w_sb;
        r1_exp      <= w_big_e;
        r1_big      <= {w_big_sig, 3'b000};
        r1_small    <= w_small_al;
        r1_spec     <= w_spec;
        r1_spec_inv <= w_spec_inv;
        r1_spec_val <= w_spec_val;
        r1_tag      <= tag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: add/subtract, count leading zeros, normalise.
  // ---------------------------------------------------------------------------
  logic [SW:0]      w_sum;
  logic [LZW-1:0]   w_lz, w_sh;
  logic [EXP_W-1:0] w_exp_m1;
  logic [EXP_W:0]   w_exp_n;
  logic [SW-1:0]    w_norm;
  logic             w_sign_n;

  assign w_sum = r1_sub ? ({1'b0, r1_big} - {1'b0, r1_small})
                        : ({1'b0, r1_big} + {1'b0, r1_small});

  // Leading-zero count of the sum below the carry bit; all zeros gives SW.
  always_comb begin
    w_lz = LZW'(SW);
    for (int i = 0; i < SW; i++) begin
      if (w_sum[i]) w_lz = LZW'(SW - 1 - i);
    end
  end

  // Normalise; the left shift stops at exponent 1, leaving subnormals unscaled.
  always_comb begin
    w_exp_m1 = r1_exp - EXP_W'(1);
    w_sh     = '0;
    if (w_sum[SW]) begin
      w_norm  = {w_sum[SW:2], |w_sum[1:0]};
      w_exp_n = {1'b0, r1_exp} + (EXP_W+1)'(1);
    end else begin
      if (32'(w_lz) <= 32'(w_exp_m1)) w_sh = w_lz;
      else                            w_sh = LZW'(w_exp_m1);
      w_norm  = w_sum[SW-1:0] << w_sh;
      w_exp_n = {1'b0, r1_exp} - (EXP_W+1)'(w_sh);
    end
    // Exact cancellation of opposite signs yields +0.
    w_sign_n = ((w_sum == '0) & r1_sub) ? 1'b0 : r1_sign;
  end

  logic             r2_sign, r2_spec, r2_spec_inv;
  logic [EXP_W:0]   r2_exp;
  logic [SW-1:0]    r2_mant;
  logic [W-1:0]     r2_spec_val;
  logic [TAG_W-1:0] r2_tag;

  // Stage 2 register: hold the normalised sum until stage 3 can take it.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r2_v        <= 1'b0;
      r2_sign     <= 1'b0;
      r2_exp      <= '0;
      r2_mant     <= '0;
      r2_spec     <= 1'b0;
      r2_spec_inv <= 1'b0;
      r2_spec_val <= '0;
      r2_tag      <= '0;
    end else if (w_adv2) begin
      r2_v <= r1_v;
      if (r1_v) begin
        r2_sign     <= w_sign_n;
        r2_exp      <= w_exp_n;
        r2_mant     <= w_norm;
        r2_spec     <= r1_spec;
        r2_spec_inv <= r1_spec_inv;
        r2_spec_val <= r1_spec_val;
        r2_tag      <= r1_tag;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3 combinational: round to nearest even, pack, overflow, flags.
  // ---------------------------------------------------------------------------
  logic             w_rup, w_inexact, w_hid;
  logic [MAN_W+1:0] w_rnd;
  logic [EXP_W:0]   w_exp_r;
  logic [MAN_W-1:0] w_frac;
  logic [W-1:0]     w_res;
  logic [3:0]       w_flg;

  // Round, renormalise on mantissa carry, then apply overrides.
  always_comb begin
    w_inexact = |r2_mant[2:0];
    w_rup     = r2_mant[2] & (r2_mant[1] | r2_mant[0] | r2_mant[3]);
    w_rnd     = {1'b0, r2_mant[SW-1:3]} + {{(MAN_W+1){1'b0}}, w_rup};
    if (w_rnd[MAN_W+1]) begin
      w_exp_r = r2_exp + (EXP_W+1)'(1);
      w_hid   = 1'b1;
      w_frac  = w_rnd[MAN_W:1];
    end else begin
      w_exp_r = r2_exp;
      w_hid   = w_rnd[MAN_W];
      w_frac  = w_rnd[MAN_W-1:0];
    end
    if (r2_spec) begin
      w_res = r2_spec_val;
      w_flg = {r2_spec_inv, 3'b000};
    end else if (w_hid && (w_exp_r >= {1'b0, EXP_ONES})) begin
      w_res = {r2_sign, EXP_ONES, {MAN_W{1'b0}}};
      w_flg = 4'b0101;
    end else begin
      // No hidden bit means the result is subnormal or zero: exponent field 0.
      w_res = {r2_sign, (w_hid ? w_exp_r[EXP_W-1:0] : {EXP_W{1'b0}}), w_frac};
      w_flg = {2'b00, ~w_hid & w_inexact, w_inexact};
    end
  end

  logic [W-1:0]     r3_rd;
  logic [TAG_W-1:0] r3_tag;
  logic [3:0]       r3_flags;

  // Stage 3 register: the visible result, held while the consumer stalls.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      r3_v     <= 1'b0;
      r3_rd    <= '0;
      r3_tag   <= '0;
      r3_flags <= '0;
    end else if (w_adv3) begin
      r3_v <= r2_v;
      if (r2_v) begin
        r3_rd    <= w_res;
        r3_tag   <= r2_tag;
        r3_flags <= w_flg;
      end
    end
  end

  assign rd      = r3_rd;
  assign tag_out = r3_tag;
  assign flags   = r3_flags;

endmodule

// File: tb/tb_fadd_pipe.sv
// tb_fadd_pipe: directed corner cases plus a randomized stream for fadd_pipe
// (single-precision format). Expected results come from an exact big-integer
// model: both operands become exact multiples of 2^-149, they are summed
// exactly, and the sum is rounded to nearest even.
module tb_fadd_pipe;

  logic        clk;
  logic        rstn;
  logic        order;
  logic        op;
  logic [4:0]  tag;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        accepted;
  logic        done;
  logic        taken;
  logic [31:0] rd;
  logic [4:0]  tag_out;
  logic [3:0]  flags;

  fadd_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(5)) dut (
    .clk(clk), .rstn(rstn), .order(order), .op(op), .tag(tag),
    .rs1(rs1), .rs2(rs2), .accepted(accepted), .done(done), .taken(taken),
    .rd(rd), .tag_out(tag_out), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rd;
    logic [4:0]  tg;
    logic [3:0]  fl;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  logic        s_acc, s_done;
  logic [31:0] s_rd;
  logic [4:0]  s_tag;
  logic [3:0]  s_fl;

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, want);
    end
  endtask

  // Exact value of a finite operand in units of 2^-149.
  function automatic logic [299:0] mag(input logic [31:0] x);
    if (x[30:23] == 8'd0) return 300'(x[22:0]);
    return 300'({1'b1, x[22:0]}) << (int'(x[30:23]) - 1);
  endfunction

  // Reference: returns {flags, result}.
  function automatic logic [35:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
    logic sa, sb, na, nb, sna, snb, ia, ib, sgn, inx;
    logic [299:0] m, q, rem, half;
    logic signed [299:0] va, vb, s;
    int p, k, e;
    sa  = a[31];
    sb  = b[31] ^ sub;
    na  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    sna = na && !a[22];
    snb = nb && !b[22];
    ia  = (a[30:23] == 8'hFF) && (a[22:0] == 0);
    ib  = (b[30:23] == 8'hFF) && (b[22:0] == 0);
    if (na || nb) return {sna | snb, 3'b000, 32'h7FC00000};
    if (ia && ib && (sa != sb)) return {4'b1000, 32'h7FC00000};
    if (ia) return {4'b0000, sa, 31'h7F800000};
    if (ib) return {4'b0000, sb, 31'h7F800000};
    va = $signed(mag(a));
    vb = $signed(mag(b));
    if (sa) va = -va;
    if (sb) vb = -vb;
    s = va + vb;
    if (s == 0) return {4'b0000, sa & sb, 31'h0};
    sgn = (s < 0);
    m   = sgn ? 300'(-s) : 300'(s);
    p = 0;
    for (int i = 0; i < 300; i++) if (m[i]) p = i;
    // Below 2^24 units the result is exact and the bit pattern is m itself.
    if (p <= 23) return {4'b0000, sgn, m[30:0]};
    k    = p - 23;
    q    = m >> k;
    rem  = m - (q << k);
    half = 300'(1) << (k - 1);
    inx  = (rem != 0);
    if ((rem > half) || ((rem == half) && q[0])) q = q + 1;
    if (q[24]) begin
      q = q >> 1;
      p = p + 1;
    end
    e = p - 22;
    if (e >= 255) return {4'b0101, sgn, 31'h7F800000};
    return {3'b000, inx, sgn, 8'(e), q[22:0]};
  endfunction

  function automatic logic [31:0] rnd_fp();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 9))
      0: begin
        case ($urandom_range(0, 7))
          0: x = 32'h00000000;
          1: x = 32'h80000000;
          2: x = 32'h7F800000;
          3: x = 32'hFF800000;
          4: x = 32'h7FC00000;
          5: x = 32'h7F800001;
          6: x = 32'h00000001;
          default: x = 32'h7F7FFFFF;
        endcase
      end
      1: x[30:23] = 8'h00;
      default: ;
    endcase
    return x;
  endfunction

  // One clock: sample at the falling edge, score, return just after rising edge.
  task automatic step();
    exp_t        e;
    logic [35:0] r;
    @(negedge clk);
    s_acc  = accepted;
    s_done = done;
    s_rd   = rd;
    s_tag  = tag_out;
    s_fl   = flags;
    if (accepted) begin
      r    = ref_add(rs1, rs2, op);
      e.rd = r[31:0];
      e.fl = r[35:32];
      e.tg = tag;
      sb_q.push_back(e);
    end
    if (done && taken) begin
      if (sb_q.size() == 0) begin
        check_val("sb_spurious_done", 64'(1), 64'(0));
      end else begin
        e = sb_q.pop_front();
        $display("txn tag=%0d rd=%h flags=%b want rd=%h flags=%b", tag_out, rd, flags, e.rd, e.fl);
        check_val("sb_rd", 64'(rd), 64'(e.rd));
        check_val("sb_tag", 64'(tag_out), 64'(e.tg));
        check_val("sb_flags", 64'(flags), 64'(e.fl));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_one(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic o, input logic [4:0] t,
                        input logic [31:0] want_rd, input logic [3:0] want_fl);
    int n;
    order = 1'b1;
    rs1   = a;
    rs2   = b;
    op    = o;
    tag   = t;
    taken = 1'b1;
    step();
    check_val({name, "_acc"}, 64'(s_acc), 64'(1));
    order = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (!s_done && n < 8);
    check_val({name, "_lat"}, 64'(n), 64'(3));
    check_val({name, "_rd"}, 64'(s_rd), 64'(want_rd));
    check_val({name, "_tag"}, 64'(s_tag), 64'(t));
    check_val({name, "_flags"}, 64'(s_fl), 64'(want_fl));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rstn  = 1'b1;
    order = 1'b1;
    op    = 1'b0;
    tag   = 5'd3;
    rs1   = 32'h3F800000;
    rs2   = 32'h3F800000;
    taken = 1'b0;
    #12;
    check_val("rst_done", 64'(done), 64'(0));
    check_val("rst_acc", 64'(accepted), 64'(0));
    check_val("rst_rd", 64'(rd), 64'(0));
    check_val("rst_tag", 64'(tag_out), 64'(0));
    check_val("rst_flags", 64'(flags), 64'(0));
    @(posedge clk);
    #1;
    rstn  = 1'b0;
    order = 1'b0;

    // Directed corner cases.
    do_one("add_1_2",   32'h3F800000, 32'h40000000, 1'b0, 5'd5,  32'h40400000, 4'b0000);
    do_one("sub_1_1",   32'h3F800000, 32'h3F800000, 1'b1, 5'd6,  32'h00000000, 4'b0000);
    do_one("neg_zero",  32'h80000000, 32'h80000000, 1'b0, 5'd7,  32'h80000000, 4'b0000);
    do_one("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 5'd8,  32'h7F800000, 4'b0101);
    do_one("inf_ninf",  32'h7F800000, 32'hFF800000, 1'b0, 5'd9,  32'h7FC00000, 4'b1000);
    do_one("sub_sub",   32'h00000001, 32'h00000001, 1'b0, 5'd10, 32'h00000002, 4'b0000);
    do_one("norm_sub",  32'h00800000, 32'h00000001, 1'b1, 5'd11, 32'h007FFFFF, 4'b0000);
    do_one("snan",      32'h7F800001, 32'h3F800000, 1'b0, 5'd12, 32'h7FC00000, 4'b1000);
    do_one("qnan",      32'h3F800000, 32'h7FC00000, 1'b0, 5'd13, 32'h7FC00000, 4'b0000);
    do_one("inf_m_ninf",32'h7F800000, 32'hFF800000, 1'b1, 5'd14, 32'h7F800000, 4'b0000);
    do_one("tie_even",  32'h3F800000, 32'h33800000, 1'b0, 5'd15, 32'h3F800000, 4'b0001);
    do_one("round_up",  32'h3F800000, 32'h33800001, 1'b0, 5'd16, 32'h3F800001, 4'b0001);
    do_one("fin_m_inf", 32'h3F800000, 32'h7F800000, 1'b1, 5'd17, 32'hFF800000, 4'b0000);

    // Backpressure: five back-to-back orders, consumer stalls for six cycles.
    taken = 1'b0;
    k = 0;
    s_acc = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 0 || s_acc) begin
        order = (k < 5);
        rs1   = rnd_fp();
        rs2   = rnd_fp();
        op    = 1'($urandom_range(0, 1));
        tag   = 5'(20 + k);
      end
      step();
      check_val("bp_acc", 64'(s_acc), 64'(k < 3));
      if (s_acc) k++;
      if (c >= 3) begin
        check_val("bp_done", 64'(s_done), 64'(1));
        check_val("bp_rd_hold", 64'(s_rd), 64'(sb_q[0].rd));
        check_val("bp_tag_hold", 64'(s_tag), 64'(sb_q[0].tg));
      end
    end
    taken = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (s_acc) begin
        order = (k < 5);
        rs1   = rnd_fp();
        rs2   = rnd_fp();
        op    = 1'($urandom_range(0, 1));
        tag   = 5'(20 + k);
      end
      step();
      check_val("drain_done", 64'(s_done), 64'(1));
      if (s_acc) k++;
    end
    order = 1'b0;
    step();
    check_val("bp_issued", 64'(k), 64'(5));
    check_val("drain_empty", 64'(sb_q.size()), 64'(0));

    // Reset with two operations in flight, one of them already presenting done.
    taken = 1'b0;
    order = 1'b1;
    rs1   = 32'h40000000;
    rs2   = 32'h40400000;
    op    = 1'b0;
    tag   = 5'd1;
    step();
    rs1 = 32'h41000000;
    tag = 5'd2;
    step();
    order = 1'b0;
    step();
    #2;
    check_val("pre_rst_done", 64'(done), 64'(1));
    order = 1'b1;
    rstn  = 1'b1;
    #1;
    check_val("mid_rst_done", 64'(done), 64'(0));
    check_val("mid_rst_rd", 64'(rd), 64'(0));
    check_val("mid_rst_tag", 64'(tag_out), 64'(0));
    check_val("mid_rst_flags", 64'(flags), 64'(0));
    check_val("mid_rst_acc", 64'(accepted), 64'(0));
    sb_q.delete();
    @(posedge clk);
    #1;
    rstn  = 1'b0;
    order = 1'b0;
    taken = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      check_val("post_rst_idle", 64'(s_done), 64'(0));
    end
    do_one("after_rst", 32'h40000000, 32'h40400000, 1'b0, 5'd4, 32'h40A00000, 4'b0000);

    // Randomized stream with random stalls on both sides.
    order = 1'b0;
    s_acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!order || s_acc) begin
        order = ($urandom_range(0, 9) < 7);
        rs1   = rnd_fp();
        rs2   = rnd_fp();
        if ($urandom_range(0, 1) == 1) rs2[30:23] = rs1[30:23] + 8'($urandom_range(0, 2));
        op    = 1'($urandom_range(0, 1));
        tag   = 5'($urandom);
      end
      taken = ($urandom_range(0, 9) < 7);
      step();
    end
    order = 1'b0;
    taken = 1'b1;
    for (int c = 0; c < 10; c++) step();
    check_val("final_empty", 64'(sb_q.size()), 64'(0));
    check_val("final_idle", 64'(done), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fadd_pipe.md
Name: fadd_pipe

Overview:
- Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor. It generalises the single-precision FPU adder to any EXP_W/MAN_W format.
- Adds: subtract mode, downstream backpressure, a tag passthrough, and exception flags.
- Sits in the FPU beside the other arithmetic units and uses the same order/accepted/done handshake, plus a `taken` acknowledge from the consumer.

Parameters:
EXP_W, 8, exponent field width (>=4)
MAN_W, 23, stored fraction width (>=4)
TAG_W, 5, width of opaque tag carried with each operation (e.g. destination register)

Ports:
clk  in  1  clock; all state updates on rising edge
rstn  in  1  reset; asynchronous, active-high (asserted = 1 clears all state immediately, despite the name)
order  in  1  request: operands valid this cycle
op  in  1  0 = rs1+rs2, 1 = rs1-rs2
tag  in  TAG_W  tag captured with operands
rs1  in  1+EXP_W+MAN_W  operand A {sign,exp,frac}
rs2  in  1+EXP_W+MAN_W  operand B
accepted  out  1  operation captured this cycle
done  out  1  rd/tag_out/flags valid
taken  in  1  consumer takes result this cycle (only meaningful while done=1)
rd  out  1+EXP_W+MAN_W  result
tag_out  out  TAG_W  tag of the result
flags  out  4  {invalid, overflow, underflow, inexact} for the result

Behaviour:
- Reset: all stage-valid bits are 0; accepted=0, done=0, rd=0, tag_out=0, flags=0. Asserting rstn mid-operation discards all in-flight operations immediately, with no done pulse.
- Pipeline: three registered stages; valid bits v1..v3.
  - S1: unpack, classify, swap, align. rs2 sign is inverted when op=1. Subnormal exponent is treated as 1 with hidden bit 0. The smaller significand is shifted right, shift saturated at MAN_W+3, with a sticky bit.
  - S2: add/subtract, leading-zero count, normalise. The left shift is limited so the exponent does not go below 1, so subnormal results are produced correctly.
  - S3: round-to-nearest-even, exponent increment on mantissa carry, special-case override, flags. rd, tag_out and flags are driven from the S3 registers.
- done = v3.
- Advance rule: adv3 = ~v3 | taken; adv2 = ~v2 | adv3; adv1 = ~v1 | adv2; accepted = order & adv1.
  - Throughput is 1 op/cycle while taken is held 1.
  - Latency: accepted in cycle t gives done=1 in cycle t+3 when there is no backpressure.
- Backpressure: while done=1 and taken=0, rd/tag_out/flags hold stable and no stage overwrites a valid stage ahead of it. Once all three stages are full, accepted=0.
- taken while done=0 is ignored.
- Simultaneous taken and a new S2→S3 advance in the same cycle: the S3 registers load the new result with no bubble.
- Special cases (qNaN = exp all-ones, fraction MSB 1, other fraction bits 0, sign 0):
  - Any NaN input → qNaN, invalid=1 only if an input was a signalling NaN.
  - inf + (−inf) → qNaN, invalid=1.
  - inf op finite → that inf, with the effective sign.
- Zero sign:
  - exact zero sum of opposite-signed operands → +0;
  - (−0)+(−0) → −0.
- Overflow: rounded exponent reaching all-ones → ±inf, overflow=1, inexact=1.
- Underflow flag: result is subnormal or zero after rounding AND inexact.
- inexact: guard, round or sticky bit set, before rounding.

Test Plan:
- Default params. 1.0+2.0 (0x3F800000, 0x40000000), op=0, tag=5, taken=1 → 3 cycles after accepted: rd=0x40400000, tag_out=5, flags=0.
- 1.0−1.0 (op=1) → rd=0x00000000. Separately, 0x80000000+0x80000000 → rd=0x80000000.
- 0x7F7FFFFF+0x7F7FFFFF → rd=0x7F800000, flags=4'b0101. 0x7F800000+0xFF800000 → rd=0x7FC00000, flags=4'b1000.
- Subnormals: 0x00000001+0x00000001 → rd=0x00000002, flags=0. 0x00800000−0x00000001 → rd=0x007FFFFF, flags=0.
- Backpressure: issue 5 back-to-back orders, hold taken=0 for 6 cycles.
  - accepted deasserts once 3 ops are in flight.
  - rd/tag_out are stable throughout.
  - Raising taken drains results in issue order, one per cycle.
- Assert rstn for one cycle with 2 ops in flight → done=0 immediately, outputs 0, no stale result after release. A new order then completes normally.
